// File: rtl/int_ack_master.sv
// Interrupt acknowledge initiator: synchronises INT, issues the two-pulse
// INTA sequence, captures the PIC vector and locks out until service ends.
module int_ack_master #(
    parameter int SYNC_STAGES = 2,
    parameter int LOW_CYCLES  = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       int_enable,
    input  logic [7:0] data_bus,
    input  logic       svc_done,
    output logic       INTA,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy
);

    localparam int MAXC = (LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] LOW_LD = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACK1_LOW,
        GAP,
        ACK2_LOW,
        DELIVER,
        WAIT_SVC
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   int_s;
    logic                   cap;

    assign int_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        case (state)
            IDLE: begin
                if (int_s && int_enable) begin
                    state_n = ACK1_LOW;
                    cnt_n   = LOW_LD;
                end
            end
            ACK1_LOW: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = ACK2_LOW;
                    cnt_n   = LOW_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ACK2_LOW: begin
                if (cnt == '0) begin
                    state_n = DELIVER;
                    cnt_n   = '0;
                    cap     = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DELIVER: begin
                state_n = WAIT_SVC;
                cnt_n   = '0;
            end
            WAIT_SVC: begin
                if (svc_done) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so INTA never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            state        <= IDLE;
            cnt          <= '0;
            INTA         <= 1'b1;
            busy         <= 1'b0;
            vector_valid <= 1'b0;
            vector       <= 8'h00;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], INT};
            state        <= state_n;
            cnt          <= cnt_n;
            INTA         <= !(state_n == ACK1_LOW || state_n == ACK2_LOW);
            busy         <= (state_n != IDLE);
            vector_valid <= cap;
            if (cap) begin
                vector <= data_bus;
            end
        end
    end

endmodule
